// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP slice carry logic: carry-in source names,
// size limits and the pipeline stage layout.
package dsp48a1_pkg;

    // Carry-in source selections for the CARRYINSEL parameter
    localparam string SEL_OPMODE5 = "OPMODE5";
    localparam string SEL_CARRYIN = "CARRYIN";

    localparam int unsigned MAX_DEPTH = 4;
    localparam int unsigned MAX_LANES = 8;

    // One pipeline stage: valid tag plus carry data. The data field is sized for the
    // widest configuration; lanes above LANES are tied to zero and trimmed in synthesis.
    typedef struct packed {
        logic                 valid;
        logic [MAX_LANES-1:0] data;
    } carry_stage_t;

endpackage

// File: rtl/carry_stage.sv
// One clock-enabled, asynchronously reset carry-in pipeline stage (data + valid).
module carry_stage
    import dsp48a1_pkg::*;
(
    input  logic         CLK,
    input  logic         RSTCARRYIN,
    input  logic         ce_i,
    input  carry_stage_t d_i,
    output carry_stage_t q_o
);

    carry_stage_t stage_q;

    // Data and valid load together so a stall can never split them
    always_ff @(posedge CLK or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) begin
            stage_q <= '0;
        end else if (ce_i) begin
            stage_q <= d_i;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/carryin_pipe.sv
// Multi-lane carry-in pipeline with valid tag and carry-out cascade register.
// Optional sticky carry-out flags are built when CARRYIN_PIPE_STICKY_EN is defined.
module carryin_pipe
    import dsp48a1_pkg::*;
#(
    parameter int unsigned LANES       = 1,
    parameter int unsigned DEPTH       = 1,
    parameter string       CARRYINSEL  = "OPMODE5",
    parameter int unsigned CARRYOUTREG = 1
) (
    input  logic             CLK,
    input  logic             RSTCARRYIN,
    input  logic             CECARRYIN,
    input  logic             CECARRYOUT,
    input  logic             IN_VALID,
    input  logic [LANES-1:0] CARRYIN,
    input  logic [LANES-1:0] OPMODE5,
    input  logic [LANES-1:0] CARRYOUT,
    output logic [LANES-1:0] CARRYIN_MUX,
    output logic             OUT_VALID,
`ifdef CARRYIN_PIPE_STICKY_EN
    input  logic             STICKY_CLR,
    output logic [LANES-1:0] CARRYOUT_STICKY,
`endif
    output logic [LANES-1:0] CARRYOUT_Q
);

    // Elaboration-time parameter checks
    if (LANES == 0 || LANES > MAX_LANES) begin : g_bad_lanes
        $error("carryin_pipe: LANES out of range");
    end
    if (DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("carryin_pipe: DEPTH out of range");
    end
    if (CARRYINSEL != SEL_OPMODE5 && CARRYINSEL != SEL_CARRYIN) begin : g_bad_sel
        $error("carryin_pipe: CARRYINSEL must be OPMODE5 or CARRYIN");
    end

    // Some configurations leave inputs unread (bypass modes, unselected source)
    logic unused_inputs;
    assign unused_inputs = ^{CARRYIN, OPMODE5, CECARRYIN, CECARRYOUT, CLK, RSTCARRYIN};

    logic [LANES-1:0] src;

    if (CARRYINSEL == SEL_OPMODE5) begin : g_src_opmode
        assign src = OPMODE5;
    end else begin : g_src_carryin
        assign src = CARRYIN;
    end

    if (DEPTH == 0) begin : g_bypass
        assign CARRYIN_MUX = src;
        assign OUT_VALID   = IN_VALID;
    end else begin : g_pipe
        carry_stage_t stage_in;
        carry_stage_t stage_q [DEPTH];

        // Pack the selected source into a stage word, unused lanes forced low
        always_comb begin
            stage_in                  = '0;
            stage_in.valid            = IN_VALID;
            stage_in.data[LANES-1:0]  = src;
        end

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            carry_stage_t stage_d;

            if (k == 0) begin : g_first
                assign stage_d = stage_in;
            end else begin : g_chain
                assign stage_d = stage_q[k-1];
            end

            carry_stage u_stage (
                .CLK        (CLK),
                .RSTCARRYIN (RSTCARRYIN),
                .ce_i       (CECARRYIN),
                .d_i        (stage_d),
                .q_o        (stage_q[k])
            );
        end

        assign CARRYIN_MUX = stage_q[DEPTH-1].data[LANES-1:0];
        assign OUT_VALID   = stage_q[DEPTH-1].valid;

        if (LANES < MAX_LANES) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^stage_q[DEPTH-1].data[MAX_LANES-1:LANES];
        end
    end

    if (CARRYOUTREG != 0) begin : g_coreg
        logic [LANES-1:0] carryout_q;

        // Cascade register, enabled independently of the carry-in pipeline
        always_ff @(posedge CLK or posedge RSTCARRYIN) begin
            if (RSTCARRYIN) begin
                carryout_q <= '0;
            end else if (CECARRYOUT) begin
                carryout_q <= CARRYOUT;
            end
        end

        assign CARRYOUT_Q = carryout_q;
    end else begin : g_cobypass
        assign CARRYOUT_Q = CARRYOUT;
    end

`ifdef CARRYIN_PIPE_STICKY_EN
    logic [LANES-1:0] sticky_set;
    logic [LANES-1:0] sticky_d;
    logic [LANES-1:0] sticky_q;

    // A set on the clearing edge wins so no carry event is ever lost
    always_comb begin
        sticky_set = CECARRYOUT ? CARRYOUT : '0;
        sticky_d   = (STICKY_CLR ? '0 : sticky_q) | sticky_set;
    end

    // Sticky flag register
    always_ff @(posedge CLK or posedge RSTCARRYIN) begin
        if (RSTCARRYIN) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign CARRYOUT_STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_carryin_pipe.sv
// Directed bench for carryin_pipe: three instances (DEPTH 2/3/0) share stimulus.
module tb_carryin_pipe;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst;
    logic       ce_in;
    logic       ce_out;
    logic       in_valid;
    logic [3:0] carryin;
    logic [3:0] opmode5;
    logic [3:0] carryout;

    logic [3:0] mux2, coq2, mux3, coq3, mux0, coq0;
    logic       ov2, ov3, ov0;

`ifdef CARRYIN_PIPE_STICKY_EN
    logic       sticky_clr;
    logic [3:0] st2, st3, st0;
`endif

    int errors = 0;
    int checks = 0;

    // DEPTH=2, CARRYIN source, registered carry-out
    carryin_pipe #(
        .LANES       (4),
        .DEPTH       (2),
        .CARRYINSEL  ("CARRYIN"),
        .CARRYOUTREG (1)
    ) u_dut2 (
        .CLK             (CLK),
        .RSTCARRYIN      (rst),
        .CECARRYIN       (ce_in),
        .CECARRYOUT      (ce_out),
        .IN_VALID        (in_valid),
        .CARRYIN         (carryin),
        .OPMODE5         (opmode5),
        .CARRYOUT        (carryout),
        .CARRYIN_MUX     (mux2),
        .OUT_VALID       (ov2),
`ifdef CARRYIN_PIPE_STICKY_EN
        .STICKY_CLR      (sticky_clr),
        .CARRYOUT_STICKY (st2),
`endif
        .CARRYOUT_Q      (coq2)
    );

    // DEPTH=3, CARRYIN source, combinational carry-out
    carryin_pipe #(
        .LANES       (4),
        .DEPTH       (3),
        .CARRYINSEL  ("CARRYIN"),
        .CARRYOUTREG (0)
    ) u_dut3 (
        .CLK             (CLK),
        .RSTCARRYIN      (rst),
        .CECARRYIN       (ce_in),
        .CECARRYOUT      (ce_out),
        .IN_VALID        (in_valid),
        .CARRYIN         (carryin),
        .OPMODE5         (opmode5),
        .CARRYOUT        (carryout),
        .CARRYIN_MUX     (mux3),
        .OUT_VALID       (ov3),
`ifdef CARRYIN_PIPE_STICKY_EN
        .STICKY_CLR      (sticky_clr),
        .CARRYOUT_STICKY (st3),
`endif
        .CARRYOUT_Q      (coq3)
    );

    // DEPTH=0, OPMODE5 source, registered carry-out
    carryin_pipe #(
        .LANES       (4),
        .DEPTH       (0),
        .CARRYINSEL  ("OPMODE5"),
        .CARRYOUTREG (1)
    ) u_dut0 (
        .CLK             (CLK),
        .RSTCARRYIN      (rst),
        .CECARRYIN       (ce_in),
        .CECARRYOUT      (ce_out),
        .IN_VALID        (in_valid),
        .CARRYIN         (carryin),
        .OPMODE5         (opmode5),
        .CARRYOUT        (carryout),
        .CARRYIN_MUX     (mux0),
        .OUT_VALID       (ov0),
`ifdef CARRYIN_PIPE_STICKY_EN
        .STICKY_CLR      (sticky_clr),
        .CARRYOUT_STICKY (st0),
`endif
        .CARRYOUT_Q      (coq0)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (mux2 !== 4'b0000) begin errors++; $display("FAIL rst_mux2: got %b want 0000", mux2); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL rst_ov2: got %b want 0", ov2); end
        checks++; if (coq2 !== 4'b0000) begin errors++; $display("FAIL rst_coq2: got %b want 0000", coq2); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL rst_ov3: got %b want 0", ov3); end
        // Reset overrides both clock enables
        ce_in = 1'b1; in_valid = 1'b1; carryin = 4'b1111; ce_out = 1'b1; carryout = 4'b1111;
        step();
        checks++; if (mux2 !== 4'b0000) begin errors++; $display("FAIL rst_ce_mux2: got %b want 0000", mux2); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL rst_ce_ov2: got %b want 0", ov2); end
        checks++; if (coq2 !== 4'b0000) begin errors++; $display("FAIL rst_ce_coq2: got %b want 0000", coq2); end
        checks++; if (coq3 !== 4'b1111) begin errors++; $display("FAIL rst_coq3_bypass: got %b want 1111", coq3); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL rst_ov0_bypass: got %b want 1", ov0); end
        in_valid = 1'b0; carryin = 4'b0000; ce_out = 1'b0; carryout = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        ce_in = 1'b1; in_valid = 1'b1; carryin = 4'b1010;
        step();
        in_valid = 1'b0; carryin = 4'b0000;
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL lat_e1_ov2: got %b want 0", ov2); end
        step();
        checks++; if (mux2 !== 4'b1010) begin errors++; $display("FAIL lat_e2_mux2: got %b want 1010", mux2); end
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL lat_e2_ov2: got %b want 1", ov2); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL lat_e2_ov3: got %b want 0", ov3); end
        step();
        checks++; if (mux2 !== 4'b0000) begin errors++; $display("FAIL lat_e3_mux2: got %b want 0000", mux2); end
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL lat_e3_ov2: got %b want 0", ov2); end
        checks++; if (mux3 !== 4'b1010) begin errors++; $display("FAIL lat_e3_mux3: got %b want 1010", mux3); end
        checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL lat_e3_ov3: got %b want 1", ov3); end
        step();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL lat_e4_ov3: got %b want 0", ov3); end
    endtask

    task automatic test_stall();
        ce_in = 1'b1; in_valid = 1'b1; carryin = 4'b0110;
        step();
        ce_in = 1'b0; in_valid = 1'b0; carryin = 4'b0000;
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL stall_e1_ov3: got %b want 0", ov3); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({ov3, mux3} !== 5'b0_0000) begin errors++; $display("FAIL stall_hold_%0d: got %b want 00000", i, {ov3, mux3}); end
        end
        ce_in = 1'b1;
        step();
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL stall_e4_ov3: got %b want 0", ov3); end
        step();
        checks++; if (mux3 !== 4'b0110) begin errors++; $display("FAIL stall_e5_mux3: got %b want 0110", mux3); end
        checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL stall_e5_ov3: got %b want 1", ov3); end
        // Stall with the sample visible at the output: it must stay put
        ce_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({ov3, mux3} !== 5'b1_0110) begin errors++; $display("FAIL stall_out_hold_%0d: got %b want 10110", i, {ov3, mux3}); end
        end
        ce_in = 1'b1;
        step();
        checks++; if ({ov3, mux3} !== 5'b0_0000) begin errors++; $display("FAIL stall_after: got %b want 00000", {ov3, mux3}); end
    endtask

    task automatic test_reset_mid();
        ce_in = 1'b1; in_valid = 1'b1; carryin = 4'b1111; ce_out = 1'b1; carryout = 4'b1111;
        step();
        step();
        checks++; if ({ov2, mux2} !== 5'b1_1111) begin errors++; $display("FAIL mid_full: got %b want 11111", {ov2, mux2}); end
        checks++; if (coq2 !== 4'b1111) begin errors++; $display("FAIL mid_full_coq2: got %b want 1111", coq2); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({ov2, mux2} !== 5'b0_0000) begin errors++; $display("FAIL mid_async: got %b want 00000", {ov2, mux2}); end
        checks++; if (coq2 !== 4'b0000) begin errors++; $display("FAIL mid_async_coq2: got %b want 0000", coq2); end
        step();
        checks++; if ({ov2, coq2} !== 5'b0_0000) begin errors++; $display("FAIL mid_held: got %b want 00000", {ov2, coq2}); end
        in_valid = 1'b0; carryout = 4'b0000;
        rst = 1'b0;
        step();
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL mid_rel1_ov2: got %b want 0", ov2); end
        step();
        // Invalid samples still carry their data through
        checks++; if ({ov2, mux2} !== 5'b0_1111) begin errors++; $display("FAIL mid_rel2: got %b want 01111", {ov2, mux2}); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL mid_new1_ov2: got %b want 0", ov2); end
        step();
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL mid_new2_ov2: got %b want 1", ov2); end
    endtask

    task automatic test_opmode();
        in_valid = 1'b1; opmode5 = 4'b0011; carryin = 4'b1100;
        #1;
        checks++; if (mux0 !== 4'b0011) begin errors++; $display("FAIL op_mux0_a: got %b want 0011", mux0); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL op_ov0_a: got %b want 1", ov0); end
        opmode5 = 4'b1100; carryin = 4'b0011;
        #1;
        checks++; if (mux0 !== 4'b1100) begin errors++; $display("FAIL op_mux0_b: got %b want 1100", mux0); end
        in_valid = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL op_ov0_c: got %b want 0", ov0); end
    endtask

    task automatic test_carryout();
        ce_in = 1'b0; ce_out = 1'b1; carryout = 4'b0000;
        step();
        checks++; if (coq2 !== 4'b0000) begin errors++; $display("FAIL co_clear: got %b want 0000", coq2); end
        ce_out = 1'b0; carryout = 4'b1000;
        #1;
        checks++; if (coq3 !== 4'b1000) begin errors++; $display("FAIL co_bypass_coq3: got %b want 1000", coq3); end
        step();
        checks++; if (coq2 !== 4'b0000) begin errors++; $display("FAIL co_disabled: got %b want 0000", coq2); end
        ce_out = 1'b1;
        step();
        checks++; if (coq2 !== 4'b1000) begin errors++; $display("FAIL co_enabled: got %b want 1000", coq2); end
        checks++; if (coq0 !== 4'b1000) begin errors++; $display("FAIL co_enabled_coq0: got %b want 1000", coq0); end
        ce_out = 1'b0; carryout = 4'b0000;
        step();
        checks++; if (coq2 !== 4'b1000) begin errors++; $display("FAIL co_hold: got %b want 1000", coq2); end
    endtask

`ifdef CARRYIN_PIPE_STICKY_EN
    task automatic test_sticky();
        sticky_clr = 1'b1; ce_out = 1'b1; carryout = 4'b0000;
        step();
        checks++; if (st2 !== 4'b0000) begin errors++; $display("FAIL st_clr0: got %b want 0000", st2); end
        sticky_clr = 1'b0; ce_out = 1'b0; carryout = 4'b0001;
        step();
        checks++; if (st2 !== 4'b0000) begin errors++; $display("FAIL st_no_ce: got %b want 0000", st2); end
        ce_out = 1'b1;
        step();
        checks++; if (st2 !== 4'b0001) begin errors++; $display("FAIL st_set2: got %b want 0001", st2); end
        checks++; if (st3 !== 4'b0001) begin errors++; $display("FAIL st_set3: got %b want 0001", st3); end
        sticky_clr = 1'b1;
        step();
        checks++; if (st2 !== 4'b0001) begin errors++; $display("FAIL st_set_wins2: got %b want 0001", st2); end
        checks++; if (st3 !== 4'b0001) begin errors++; $display("FAIL st_set_wins3: got %b want 0001", st3); end
        carryout = 4'b0000;
        step();
        checks++; if (st2 !== 4'b0000) begin errors++; $display("FAIL st_clr_only2: got %b want 0000", st2); end
        checks++; if (st0 !== 4'b0000) begin errors++; $display("FAIL st_clr_only0: got %b want 0000", st0); end
        sticky_clr = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; ce_in = 1'b0; ce_out = 1'b0; in_valid = 1'b0;
        carryin = '0; opmode5 = '0; carryout = '0;
`ifdef CARRYIN_PIPE_STICKY_EN
        sticky_clr = 1'b0;
`endif
        test_reset();
        test_latency();
        test_stall();
        test_reset_mid();
        test_opmode();
        test_carryout();
`ifdef CARRYIN_PIPE_STICKY_EN
        test_sticky();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
